mousetrap_pipe_sync: RTL and testbench

Clocked, parametrised successor to the single-stage 2-phase MOUSETRAP element. It is a DEPTH-stage transition-signalling (2-phase, bundled-data) pipeline FIFO of WIDTH-bit tokens, with each stage modelled as a clock-enabled register. It also provides a sticky sender-protocol error flag and an optional occupancy count. It sits between 2-phase producers and consumers in synchronous islands, and serves as a cycle-accurate reference for the async pipelines.

---
 rtl/mousetrap_pipe_sync.sv | 133 +++++++++++++
 tb/tb_mousetrap_pipe_sync.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mousetrap_pipe_sync.sv
// rtl/mousetrap_pipe_sync.sv - clocked DEPTH-stage 2-phase bundled-data MOUSETRAP pipeline FIFO
//
// Purpose: transition-signalling pipeline of WIDTH-bit tokens. Each stage holds a
// done bit and a data register and loads when its request differs from its done
// bit while the stage is empty. A sticky flag records sender protocol violations.
// Optional macro MOUSETRAP_PIPE_OCCUPANCY_EN adds a registered full-stage count.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rstn       asynchronous active-low reset
//   reqN       upstream request, each toggle offers one token
//   datain     upstream data, bundled with reqN
//   ackNm1     upstream acknowledge (done of stage 0)
//   doneN      downstream request (done of last stage)
//   dataout    data of last stage
//   ackN       downstream acknowledge, a toggle consumes the output token
//   proto_err  sticky: reqN toggled while a previous offer was still pending
//   occupancy  number of full stages (MOUSETRAP_PIPE_OCCUPANCY_EN only)
module mousetrap_pipe_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             reqN,
  input  logic [WIDTH-1:0] datain,
  output logic             ackNm1,
  output logic             doneN,
  output logic [WIDTH-1:0] dataout,
  input  logic             ackN,
  output logic             proto_err
`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0]            done;
  logic [DEPTH-1:0]            done_nxt;
  logic [DEPTH-1:0]            req_v;
  logic [DEPTH-1:0]            ack_v;
  logic [DEPTH-1:0]            load;
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0][WIDTH-1:0] data_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] stage_in;
  logic                        reqN_q;

  // Neighbour wiring: request comes from the stage before, acknowledge from the
  // stage after; the chain ends on the external handshake signals.
  always_comb begin
    req_v    = '0;
    ack_v    = '0;
    stage_in = '0;
    req_v[0]    = reqN;
    stage_in[0] = datain;
    for (int i = 1; i < DEPTH; i++) begin
      req_v[i]    = done[i-1];
      stage_in[i] = data[i-1];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      ack_v[i] = done[i+1];
    end
    ack_v[DEPTH-1] = ackN;
  end

  // A stage loads when a new token is offered and it is currently empty.
  // Every stage looks only at pre-edge values, so a token advances one stage per edge.
  assign load = (req_v ^ done) & ~(done ^ ack_v);

  always_comb begin
    done_nxt = done;
    data_nxt = data;
    for (int i = 0; i < DEPTH; i++) begin
      if (load[i]) begin
        done_nxt[i] = req_v[i];
        data_nxt[i] = stage_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done <= '0;
      data <= '0;
    end else begin
      done <= done_nxt;
      data <= data_nxt;
    end
  end

  // reqN_q != ackNm1 means the last offer has not yet been taken by stage 0;
  // any further reqN toggle in that window is a sender violation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reqN_q    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      reqN_q <= reqN;
      if ((reqN != reqN_q) && (reqN_q != done[0])) begin
        proto_err <= 1'b1;
      end
    end
  end

`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_nxt;

  // Count full stages as they will be after this edge, so the registered value
  // matches the stage state it is reported alongside.
  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      occ_nxt = occ_nxt + OCC_W'(done_nxt[i] ^ done_nxt[i+1]);
    end
    occ_nxt = occ_nxt + OCC_W'(done_nxt[DEPTH-1] ^ ackN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_nxt;
    end
  end
`endif

  assign ackNm1  = done[0];
  assign doneN   = done[DEPTH-1];
  assign dataout = data[DEPTH-1];

endmodule

// File: tb/tb_mousetrap_pipe_sync.sv
// tb/tb_mousetrap_pipe_sync.sv - directed self-checking bench for mousetrap_pipe_sync
module tb_mousetrap_pipe_sync;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       reqN = 1'b0;
  logic       ackN = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       ackNm1;
  logic       doneN;
  logic [7:0] dataout;
  logic       proto_err;

  logic       req1 = 1'b0;
  logic       ack1 = 1'b0;
  logic       din1 = 1'b0;
  logic       ackm1_1;
  logic       done1;
  logic       dout1;
  logic       err1;

`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
  logic [2:0] occ;
  logic       occ1;
`endif

  int checks = 0;
  int errors = 0;

  mousetrap_pipe_sync #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .reqN      (reqN),
    .datain    (datain),
    .ackNm1    (ackNm1),
    .doneN     (doneN),
    .dataout   (dataout),
    .ackN      (ackN),
    .proto_err (proto_err)
`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
    ,
    .occupancy (occ)
`endif
  );

  mousetrap_pipe_sync #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .clk       (clk),
    .rstn      (rstn),
    .reqN      (req1),
    .datain    (din1),
    .ackNm1    (ackm1_1),
    .doneN     (done1),
    .dataout   (dout1),
    .ackN      (ack1),
    .proto_err (err1)
`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
    ,
    .occupancy (occ1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one token and wait (bounded) for stage 0 to acknowledge it.
  task automatic send(input logic [7:0] d);
    reqN   = ~reqN;
    datain = d;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (ackNm1 === reqN) break;
    end
    chk("send_ack", ackNm1, reqN);
  endtask

  logic [7:0] exp_q [32];
  int         tx;
  int         rx;
  int         n;
  logic       want;

  initial begin
    // Reset state
    tick(2);
    chk("rst_ackNm1", ackNm1, 0);
    chk("rst_doneN", doneN, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_proto_err", proto_err, 0);
`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
    chk("rst_occ", occ, 0);
`endif
    rstn = 1'b1;
    tick(1);

    // Single token, forward latency DEPTH edges
    reqN   = 1'b1;
    datain = 8'hA5;
    tick(1);
    chk("t1_ack_edge1", ackNm1, 1);
    chk("t1_done_edge1", doneN, 0);
    tick(2);
    chk("t1_done_edge3", doneN, 0);
    tick(1);
    chk("t1_done_edge4", doneN, 1);
    chk("t1_data_edge4", dataout, 8'hA5);
`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
    chk("t1_occ_one", occ, 1);
`endif
    ackN = 1'b1;
    tick(1);
`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
    chk("t1_occ_empty", occ, 0);
`endif
    chk("t1_proto_err", proto_err, 0);

    // Fill to full with ackN held, fifth token stalls
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    reqN   = ~reqN;
    datain = 8'h05;
    tick(8);
    want = !reqN;
    chk("full_ack_held", ackNm1, want);
    chk("full_doneN", doneN, 0);
    chk("full_dataout", dataout, 8'h01);
`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
    chk("full_occ", occ, 4);
`endif
    ackN = ~ackN;
    n = 0;
    while (ackNm1 !== reqN && n < 5) begin
      tick(1);
      n++;
    end
    chk("bubble_ack", ackNm1, reqN);
    chk("bubble_edges", n, 4);
    for (int t = 2; t <= 5; t++) begin
      n = 0;
      while (doneN === ackN && n < 10) begin
        tick(1);
        n++;
      end
      chk("full_order", dataout, t);
      ackN = ~ackN;
    end
    tick(10);
    chk("drain_empty", doneN, ackN);
`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
    chk("drain_occ", occ, 0);
`endif
    chk("fill_proto_err", proto_err, 0);

    // Streaming, producer and consumer as fast as allowed
    for (int i = 0; i < 32; i++) exp_q[i] = 8'($urandom_range(0, 255));
    tx = 0;
    rx = 0;
    for (int c = 0; c < 600 && rx < 32; c++) begin
      if (doneN !== ackN) begin
        chk("stream_data", dataout, exp_q[rx]);
        rx++;
        ackN = ~ackN;
      end
      if (tx < 32 && ackNm1 === reqN) begin
        reqN   = ~reqN;
        datain = exp_q[tx];
        tx++;
      end
      tick(1);
    end
    chk("stream_count", rx, 32);
    tick(8);
    chk("stream_no_extra", doneN, ackN);
    chk("stream_proto_err", proto_err, 0);

    // Protocol error: second toggle while the first offer is pending
    send(8'h10);
    send(8'h20);
    send(8'h30);
    send(8'h40);
    tick(3);
    reqN   = ~reqN;
    datain = 8'h50;
    tick(3);
    chk("proto_single_ok", proto_err, 0);
    reqN = ~reqN;
    tick(1);
    chk("proto_err_set", proto_err, 1);
    ackN = ~ackN;
    tick(10);
    chk("proto_err_sticky", proto_err, 1);

    // Reset clears the flag, then reset mid-stream with 3 tokens stored
    rstn = 1'b0;
    reqN = 1'b0;
    ackN = 1'b0;
    #1;
    chk("rst_err_clear", proto_err, 0);
    tick(2);
    rstn = 1'b1;
    tick(1);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    tick(6);
    chk("mid_doneN", doneN, 1);
    chk("mid_ackNm1", ackNm1, 1);
    chk("mid_dataout", dataout, 8'h11);
`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
    chk("mid_occ", occ, 3);
`endif
    #3;
    rstn = 1'b0;
    #1;
    chk("async_doneN", doneN, 0);
    chk("async_ackNm1", ackNm1, 0);
    chk("async_dataout", dataout, 0);
`ifdef MOUSETRAP_PIPE_OCCUPANCY_EN
    chk("async_occ", occ, 0);
`endif
    reqN = 1'b0;
    ackN = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(1);
    send(8'h3C);
    tick(3);
    chk("post_rst_doneN", doneN, 1);
    chk("post_rst_data", dataout, 8'h3C);

    // DEPTH=1, WIDTH=1: one edge per hop, a full stage holds
    req1 = 1'b1;
    din1 = 1'b1;
    tick(1);
    chk("d1_done", done1, 1);
    chk("d1_ack", ackm1_1, 1);
    chk("d1_dout", dout1, 1);
    req1 = 1'b0;
    din1 = 1'b0;
    tick(1);
    chk("d1_full_hold", done1, 1);
    chk("d1_full_data", dout1, 1);
    ack1 = 1'b1;
    tick(1);
    chk("d1_bubble_load", done1, 0);
    chk("d1_bubble_data", dout1, 0);
    for (int i = 0; i < 4; i++) begin
      ack1 = done1;
      tick(1);
      req1 = ~req1;
      din1 = i[0];
      tick(1);
      chk("d1_alt_done", done1, req1);
      chk("d1_alt_data", dout1, din1);
    end
    chk("d1_proto_err", err1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
